// File: rtl/fifo_audio_drain_pkg.sv
// Shared types and defaults for the audio FIFO drain: FSM state encoding and sample type.
package fifo_audio_drain_pkg;

    localparam int DATA_WIDTH_DEF = 24;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_L,
        FETCH_R,
        SEND
    } drain_state_t;

    typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

endpackage

// File: rtl/fifo_audio_drain_if.sv
// FIFO read side plus codec write side of the drain; master = drain, slave = FIFO/codec.
interface fifo_audio_drain_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_r_data;
    logic                  fifo_rd;
    logic                  codec_write_ready;
    logic                  codec_write;
    logic [DATA_WIDTH-1:0] codec_left;
    logic [DATA_WIDTH-1:0] codec_right;

    // Pop: fifo_rd=1 while fifo_empty=0 consumes the head word. Write: codec_write=1 only
    // while codec_write_ready=1; the pair on codec_left/right is accepted that cycle.
    modport master (
        input  fifo_empty, fifo_r_data, codec_write_ready,
        output fifo_rd, codec_write, codec_left, codec_right
    );

    modport slave (
        output fifo_empty, fifo_r_data, codec_write_ready,
        input  fifo_rd, codec_write, codec_left, codec_right
    );

endinterface

// File: rtl/fifo_audio_drain_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fifo_audio_drain.sv
// Pops left/right samples from a FWFT FIFO, writes stereo pairs to the codec and
// substitutes a fallback pair (counted) whenever the FIFO runs dry mid-fetch.
module fifo_audio_drain
    import fifo_audio_drain_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int REPEAT_LAST = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    fifo_audio_drain_if.master    audio_bus,
    output logic [CNT_WIDTH-1:0]  underrun_cnt,
    output drain_state_t          o_dbg_state
);
    drain_state_t          r_state;
    drain_state_t          w_next_state;
    logic [DATA_WIDTH-1:0] r_left_q;
    logic [DATA_WIDTH-1:0] r_right_q;
    logic [DATA_WIDTH-1:0] r_last_l;
    logic [DATA_WIDTH-1:0] r_last_r;
    logic                  w_pop;
    logic                  w_underrun;
    logic                  w_send;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_left_q  <= '0;
            r_right_q <= '0;
            r_last_l  <= '0;
            r_last_r  <= '0;
        end else begin
            if (w_pop && (r_state == FETCH_L)) r_left_q  <= audio_bus.fifo_r_data;
            if (w_pop && (r_state == FETCH_R)) r_right_q <= audio_bus.fifo_r_data;
            if (w_send) begin
                r_last_l <= r_left_q;
                r_last_r <= r_right_q;
            end
        end
    end

    // Disabling in FETCH_L abandons an empty pair; once a left word is held the pair completes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (enable) w_next_state = FETCH_L;
            FETCH_L: begin
                if (!enable)                      w_next_state = IDLE;
                else if (!audio_bus.fifo_empty)   w_next_state = FETCH_R;
            end
            FETCH_R: if (!audio_bus.fifo_empty) w_next_state = SEND;
            SEND:    if (audio_bus.codec_write_ready) w_next_state = enable ? FETCH_L : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_underrun = 1'b0;
        w_send     = 1'b0;
        case (r_state)
            FETCH_L: begin
                if (enable) begin
                    w_pop      = !audio_bus.fifo_empty;
                    w_underrun = audio_bus.fifo_empty && audio_bus.codec_write_ready;
                end
            end
            FETCH_R: begin
                w_pop      = !audio_bus.fifo_empty;
                w_underrun = audio_bus.fifo_empty && audio_bus.codec_write_ready;
            end
            SEND:    w_send = audio_bus.codec_write_ready;
            default: ;
        endcase
    end

    always_comb begin
        audio_bus.fifo_rd     = w_pop;
        audio_bus.codec_write = w_underrun || w_send;
        audio_bus.codec_left  = r_left_q;
        audio_bus.codec_right = r_right_q;
        if (w_underrun) begin
            audio_bus.codec_left  = (REPEAT_LAST != 0) ? r_last_l : '0;
            audio_bus.codec_right = (REPEAT_LAST != 0) ? r_last_r : '0;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_underrun_cnt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_inc   (w_underrun),
        .o_count (underrun_cnt)
    );

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_audio_drain.sv
// Bench for fifo_audio_drain: three DUT variants (default, zero fallback, 4-bit counter)
// share one FIFO model and are checked against a pair-assembly reference model.
module tb_fifo_audio_drain;
    import fifo_audio_drain_pkg::*;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          rdy = 1'b0;
    logic          tb_empty = 1'b1;
    logic [DW-1:0] tb_head = '0;

    logic [15:0]   cnt_a, cnt_z;
    logic [3:0]    cnt_s;
    drain_state_t  st_a, st_z, st_s;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_audio_drain_if #(.DATA_WIDTH(DW)) bus_a ();
    fifo_audio_drain_if #(.DATA_WIDTH(DW)) bus_z ();
    fifo_audio_drain_if #(.DATA_WIDTH(DW)) bus_s ();

    assign bus_a.fifo_empty = tb_empty;
    assign bus_a.fifo_r_data = tb_head;
    assign bus_a.codec_write_ready = rdy;
    assign bus_z.fifo_empty = tb_empty;
    assign bus_z.fifo_r_data = tb_head;
    assign bus_z.codec_write_ready = rdy;
    assign bus_s.fifo_empty = tb_empty;
    assign bus_s.fifo_r_data = tb_head;
    assign bus_s.codec_write_ready = rdy;

    fifo_audio_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(16), .REPEAT_LAST(1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .audio_bus(bus_a),
        .underrun_cnt(cnt_a), .o_dbg_state(st_a));
    fifo_audio_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(16), .REPEAT_LAST(0)) dut_z (
        .clk(clk), .reset(reset), .enable(enable), .audio_bus(bus_z),
        .underrun_cnt(cnt_z), .o_dbg_state(st_z));
    fifo_audio_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .REPEAT_LAST(1)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .audio_bus(bus_s),
        .underrun_cnt(cnt_s), .o_dbg_state(st_s));

    // FIFO contents and reference model: a flag for "draining", the words gathered for the
    // pair in progress, the last pair handed over and an unbounded count of fallback pairs.
    logic [DW-1:0]   fifo_q[$];
    bit              m_active;
    logic [DW-1:0]   m_fetch[$];
    logic [DW-1:0]   m_last_l, m_last_r;
    int              m_cnt;
    logic [2*DW-1:0] exp_q[$];

    logic          s_rd, s_wr;
    logic [DW-1:0] s_l, s_r;
    drain_state_t  s_st;

    typedef struct {
        logic          en;
        logic          rdy;
        logic          e_rd;
        logic          e_wr;
        logic          e_chk_d;
        logic [DW-1:0] e_l;
        logic [DW-1:0] e_r;
        drain_state_t  e_st;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pins_update();
        tb_empty = (fifo_q.size() == 0);
        tb_head  = tb_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        pins_update();
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_fetch.delete();
        m_last_l = '0;
        m_last_r = '0;
        m_cnt    = 0;
        exp_q.delete();
    endtask

    task automatic cycle(input logic en, input logic r);
        int            n;
        logic          e_rd, e_wr, e_dat;
        logic [DW-1:0] e_l, e_r, e_lz, e_rz, head_snap;
        logic          empty_snap;
        drain_state_t  e_st;
        logic [2*DW-1:0] got;
        enable = en;
        rdy    = r;
        pins_update();
        @(negedge clk);
        n = m_fetch.size();
        empty_snap = tb_empty;
        head_snap  = tb_head;
        e_rd = 1'b0; e_wr = 1'b0; e_dat = 1'b0;
        e_l = '0; e_r = '0; e_lz = '0; e_rz = '0;
        e_st = !m_active ? IDLE : (n == 0 ? FETCH_L : (n == 1 ? FETCH_R : SEND));
        if (m_active) begin
            if (n == 2) begin
                e_dat = 1'b1; e_wr = r;
                e_l = m_fetch[0]; e_r = m_fetch[1]; e_lz = e_l; e_rz = e_r;
            end else if (n == 0 && !en) begin
                e_rd = 1'b0;
            end else if (!empty_snap) begin
                e_rd = 1'b1;
            end else if (r) begin
                e_wr = 1'b1; e_dat = 1'b1;
                e_l = m_last_l; e_r = m_last_r;
            end
        end
        s_rd = bus_a.fifo_rd; s_wr = bus_a.codec_write;
        s_l = bus_a.codec_left; s_r = bus_a.codec_right; s_st = st_a;
        chk("fifo_rd", s_rd, e_rd);
        chk("codec_write", s_wr, e_wr);
        chk("state", s_st, e_st);
        chk("zero_write", bus_z.codec_write, e_wr);
        chk("sat_rd", bus_s.fifo_rd, e_rd);
        chk("cnt", cnt_a, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("cnt_zero", cnt_z, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("cnt_sat", cnt_s, (m_cnt > 15) ? 15 : m_cnt);
        if (e_dat) begin
            chk("left", s_l, e_l);
            chk("right", s_r, e_r);
            chk("zero_left", bus_z.codec_left, e_lz);
            chk("zero_right", bus_z.codec_right, e_rz);
        end
        if (e_wr) exp_q.push_back({e_l, e_r});
        if (s_wr) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", 1, 0);
            end else begin
                got = exp_q.pop_front();
                chk("sb_pair", {s_l, s_r}, got);
            end
        end
        @(posedge clk);
        if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (!m_active) begin
            m_active = en;
        end else if (n == 2) begin
            if (r) begin
                m_last_l = m_fetch[0];
                m_last_r = m_fetch[1];
                m_fetch.delete();
                m_active = en;
            end
        end else if (n == 0 && !en) begin
            m_active = 1'b0;
        end else if (!empty_snap) begin
            m_fetch.push_back(head_snap);
        end else if (r) begin
            m_cnt++;
        end
        #1;
        pins_update();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_fifo_rd", bus_a.fifo_rd, 0);
        chk("rst_write", bus_a.codec_write, 0);
        chk("rst_left", bus_a.codec_left, 0);
        chk("rst_right", bus_a.codec_right, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_state", st_a, IDLE);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 20; i++) begin
            tbl[i] = '{en: 1'b1, rdy: 1'b0, e_rd: 1'b0, e_wr: 1'b0, e_chk_d: 1'b1,
                       e_l: 24'h000333, e_r: 24'h000444, e_st: SEND};
        end
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, IDLE};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0, FETCH_L};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0, FETCH_R};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000111, 24'h000222, SEND};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, IDLE};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, IDLE};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0, FETCH_L};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0, FETCH_R};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000333, 24'h000444, SEND};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, IDLE};

        model_reset();
        pins_update();
        do_reset();

        // Disabled drain must leave a loaded FIFO untouched.
        push(24'h000111); push(24'h000222); push(24'h000333); push(24'h000444);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)));
            chk("idle_no_rd", s_rd, 0);
        end

        // Normal pair, then a pair held for 10 cycles of backpressure.
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].en, tbl[i].rdy);
            chk("tbl_rd", s_rd, tbl[i].e_rd);
            chk("tbl_wr", s_wr, tbl[i].e_wr);
            chk("tbl_state", s_st, tbl[i].e_st);
            if (tbl[i].e_chk_d) begin
                chk("tbl_left", s_l, tbl[i].e_l);
                chk("tbl_right", s_r, tbl[i].e_r);
            end
        end

        // Underrun after a pair repeats that pair (zeros on the REPEAT_LAST=0 variant).
        push(24'hAAAAAA); push(24'h555555);
        repeat (4) cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1);
            chk("ur_wr", s_wr, 1);
            chk("ur_left", s_l, 24'hAAAAAA);
            chk("ur_right", s_r, 24'h555555);
            chk("ur_zero_left", bus_z.codec_left, 0);
        end
        cycle(1'b0, 1'b1);
        chk("ur_cnt", cnt_a, 3);
        chk("ur_cnt_zero", cnt_z, 3);

        // Underrun between left and right keeps the left word and the FETCH_R state.
        push(24'h000123);
        repeat (2) cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1);
            chk("split_wr", s_wr, 1);
            chk("split_state", s_st, FETCH_R);
            chk("split_left", s_l, 24'hAAAAAA);
        end
        push(24'h000456);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        chk("split_pair_left", s_l, 24'h000123);
        chk("split_pair_right", s_r, 24'h000456);
        chk("split_cnt", cnt_a, 6);

        // Reset with a half-built pair in flight.
        push(24'h000777); push(24'h000888);
        repeat (2) cycle(1'b1, 1'b1);
        do_reset();

        // 4-bit counter saturates and holds at F.
        repeat (22) cycle(1'b1, 1'b1);
        chk("sat_cnt", cnt_s, 4'hF);
        chk("sat_wide_cnt", cnt_a, 20);
        repeat (3) cycle(1'b1, 1'b1);
        chk("sat_hold", cnt_s, 4'hF);
        push(24'h000999);
        repeat (2) cycle(1'b0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) push(DW'($urandom));
            if (i == 700) do_reset();
            cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0));
        end
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
